// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, IF/ID field layout and bubble word.
// Decode slices the IF/ID bundle with these same field positions.
package fetch_pkg;

  typedef enum logic [1:0] {
    VEC_HI = 2'd0,
    VEC_LO = 2'd1,
    RUN    = 2'd2
  } fetch_state_e;

  localparam int IFID_W    = 69;
  localparam int INPORT_HI = 68;
  localparam int INPORT_LO = 53;
  localparam int PC_HI     = 52;
  localparam int PC_LO     = 21;
  localparam int INSTR_HI  = 20;
  localparam int INSTR_LO  = 5;
  localparam int INT_BIT   = 4;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  function automatic logic [IFID_W-1:0] pack_ifid(input logic [15:0] inport,
                                                  input logic [31:0] pc,
                                                  input logic [15:0] instr,
                                                  input logic        intr);
    logic [IFID_W-1:0] r;
    r = '0;
    r[INPORT_HI:INPORT_LO] = inport;
    r[PC_HI:PC_LO]         = pc;
    r[INSTR_HI:INSTR_LO]   = instr;
    r[INT_BIT]             = intr;
    return r;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID output.
// master = fetch stage, slave = its environment (hazard unit, imem, decode).
interface fetch_if #(parameter int ADDR_W = 32);
  import fetch_pkg::*;

  logic              Stall;
  logic              Flush;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic              IntReq;
  logic [15:0]       InPort;
  logic [15:0]       IMemData;
  logic [ADDR_W-1:0] IMemAddr;
  logic [IFID_W-1:0] Out;
  logic              Busy;

  modport master (
    input  Stall, Flush, BranchTaken, BranchTarget, IntReq, InPort, IMemData,
    output IMemAddr, Out, Busy
  );

  modport slave (
    output Stall, Flush, BranchTaken, BranchTarget, IntReq, InPort, IMemData,
    input  IMemAddr, Out, Busy
  );

endinterface

// File: rtl/pc_vector_loader.sv
// Two-cycle vector fetch (high word, then low word) from the reset or interrupt vector.
// done is high in VEC_LO, when loaded_pc is valid; a new load starts on inject from RUN.
module pc_vector_loader
  import fetch_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] RST_VEC = 32'd0,
  parameter logic [ADDR_W-1:0] INT_VEC = 32'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inject,
  input  logic [15:0]       imem_data,
  output fetch_state_e      state,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [ADDR_W-1:0] loaded_pc,
  output logic              done,
  output logic              busy
);

  fetch_state_e      state_q, state_d;
  logic [15:0]       hi_word_q, hi_word_d;
  logic              vsel_q, vsel_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] vbase;

  always_comb begin
    state_d   = state_q;
    hi_word_d = hi_word_q;
    vsel_d    = vsel_q;
    unique case (state_q)
      VEC_HI: begin
        hi_word_d = imem_data;
        state_d   = VEC_LO;
      end
      VEC_LO: state_d = RUN;
      RUN: begin
        if (inject) begin
          vsel_d  = 1'b1;
          state_d = VEC_HI;
        end
      end
      default: state_d = VEC_HI;
    endcase
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= VEC_HI;
      hi_word_q <= 16'h0000;
      vsel_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      hi_word_q <= hi_word_d;
      vsel_q    <= vsel_d;
      busy_q    <= busy_d;
    end
  end

  assign vbase     = vsel_q ? INT_VEC : RST_VEC;
  assign vec_addr  = (state_q == VEC_LO) ? vbase + ADDR_W'(1) : vbase;
  assign loaded_pc = {hi_word_q, imem_data};
  assign done      = (state_q == VEC_LO);
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, interrupt capture and registered IF/ID bundle.
// One word per cycle in RUN; Stall holds PC and Out; vector loads take two bubble cycles.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] RST_VEC = 32'd0,
  parameter logic [ADDR_W-1:0] INT_VEC = 32'd2,
  parameter logic [15:0]       NOP     = NOP_WORD
) (
  input  logic     Clk,
  input  logic     Rst,
  fetch_if.master  bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] vec_addr, loaded_pc, pc_inc;
  logic              done, busy, inject, irq_rise;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              intpend_q, intpend_d;
  logic              irq_dly_q;
  logic [IFID_W-1:0] out_q, out_d, bubble;

  pc_vector_loader #(
    .ADDR_W  (ADDR_W),
    .RST_VEC (RST_VEC),
    .INT_VEC (INT_VEC)
  ) u_loader (
    .clk       (Clk),
    .rst_n     (Rst),
    .inject    (inject),
    .imem_data (bus.IMemData),
    .state     (state),
    .vec_addr  (vec_addr),
    .loaded_pc (loaded_pc),
    .done      (done),
    .busy      (busy)
  );

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign bubble   = pack_ifid(bus.InPort, pc_inc, NOP, 1'b0);
  assign irq_rise = bus.IntReq & ~irq_dly_q;
  // Branch and stall outrank injection, so a pending interrupt simply waits.
  assign inject   = (state == RUN) && !bus.BranchTaken && !bus.Stall && intpend_q;

  always_comb begin
    pc_d      = pc_q;
    out_d     = out_q;
    intpend_d = inject ? irq_rise : (intpend_q | irq_rise);
    if (state != RUN) begin
      out_d = bubble;
      if (done) pc_d = loaded_pc;
    end else if (bus.BranchTaken) begin
      pc_d  = bus.BranchTarget;
      out_d = bubble;
    end else if (bus.Stall) begin
      out_d = out_q;
    end else if (intpend_q) begin
      out_d = pack_ifid(bus.InPort, pc_q, NOP, 1'b1);
    end else if (bus.Flush) begin
      out_d = bubble;
      pc_d  = pc_inc;
    end else begin
      out_d = pack_ifid(bus.InPort, pc_inc, bus.IMemData, 1'b0);
      pc_d  = pc_inc;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q      <= '0;
      intpend_q <= 1'b0;
      irq_dly_q <= 1'b0;
      out_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      intpend_q <= intpend_d;
      irq_dly_q <= bus.IntReq;
      out_q     <= out_d;
    end
  end

  assign bus.IMemAddr = (state == RUN) ? pc_q : vec_addr;
  assign bus.Out      = out_q;
  assign bus.Busy     = busy;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector-table bench for fetch_stage with a small behavioural instruction memory.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fetch_if #(.ADDR_W(32)) ifc ();

  fetch_stage #(
    .ADDR_W  (32),
    .RST_VEC (32'd0),
    .INT_VEC (32'd2),
    .NOP     (16'h0000)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (ifc)
  );

  logic [15:0] mem [0:511];
  assign ifc.IMemData = mem[ifc.IMemAddr[8:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic        irq;
    logic [15:0] ip;
    logic [31:0] addr;
    logic [15:0] instr;
    logic [31:0] pc;
    logic        intb;
    logic        busy;
    logic [15:0] exp_ip;
  } vec_t;

  vec_t tbl [0:30];

  function automatic vec_t mk(input logic s, input logic f, input logic b,
                              input logic [31:0] t, input logic i, input logic [15:0] ip,
                              input logic [31:0] a, input logic [15:0] ins,
                              input logic [31:0] p, input logic ib, input logic bz,
                              input logic [15:0] eip);
    vec_t v;
    v.stall = s; v.flush = f; v.br = b; v.tgt = t; v.irq = i; v.ip = ip;
    v.addr = a; v.instr = ins; v.pc = p; v.intb = ib; v.busy = bz; v.exp_ip = eip;
    return v;
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ifc.Stall = 0; ifc.Flush = 0; ifc.BranchTaken = 0;
    ifc.BranchTarget = 0; ifc.IntReq = 0; ifc.InPort = 16'h5A5A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [15:0] D = 16'h5A5A;

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 512; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0]  = 16'h0000;
    mem[1]  = 16'h0010;
    mem[2]  = 16'h0000;
    mem[3]  = 16'h0100;
    mem[16] = 16'h1234;

    //          stall flush br tgt          irq ip        addr          instr     pc           int busy exp_ip
    tbl[0]  = mk(0, 0, 0, 32'h0,        0, D,        32'h1,        16'h0,    32'h1,       0, 1, D);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, D,        32'h10,       16'h0,    32'h1,       0, 0, D);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, D,        32'h11,       16'h1234, 32'h11,      0, 0, D);
    tbl[3]  = mk(1, 0, 0, 32'h0,        0, 16'h1111, 32'h11,       16'h1234, 32'h11,      0, 0, D);
    tbl[4]  = mk(1, 0, 0, 32'h0,        0, 16'h1111, 32'h11,       16'h1234, 32'h11,      0, 0, D);
    tbl[5]  = mk(1, 0, 0, 32'h0,        0, 16'h1111, 32'h11,       16'h1234, 32'h11,      0, 0, D);
    tbl[6]  = mk(0, 0, 0, 32'h0,        0, 16'h2222, 32'h12,       16'hA011, 32'h12,      0, 0, 16'h2222);
    tbl[7]  = mk(1, 1, 1, 32'h40,       0, D,        32'h40,       16'h0,    32'h13,      0, 0, D);
    tbl[8]  = mk(0, 0, 0, 32'h0,        0, D,        32'h41,       16'hA040, 32'h41,      0, 0, D);
    tbl[9]  = mk(0, 1, 0, 32'h0,        0, D,        32'h42,       16'h0,    32'h42,      0, 0, D);
    tbl[10] = mk(1, 1, 0, 32'h0,        0, D,        32'h42,       16'h0,    32'h42,      0, 0, D);
    tbl[11] = mk(0, 0, 0, 32'h0,        0, D,        32'h43,       16'hA042, 32'h43,      0, 0, D);
    tbl[12] = mk(0, 0, 1, 32'h20,       1, D,        32'h20,       16'h0,    32'h44,      0, 0, D);
    tbl[13] = mk(0, 0, 0, 32'h0,        0, D,        32'h2,        16'h0,    32'h20,      1, 1, D);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, D,        32'h3,        16'h0,    32'h21,      0, 1, D);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, D,        32'h100,      16'h0,    32'h21,      0, 0, D);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, D,        32'h101,      16'hA100, 32'h101,     0, 0, D);
    tbl[17] = mk(1, 0, 0, 32'h0,        1, D,        32'h101,      16'hA100, 32'h101,     0, 0, D);
    tbl[18] = mk(1, 0, 0, 32'h0,        1, D,        32'h101,      16'hA100, 32'h101,     0, 0, D);
    tbl[19] = mk(0, 0, 0, 32'h0,        0, D,        32'h2,        16'h0,    32'h101,     1, 1, D);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, D,        32'h3,        16'h0,    32'h102,     0, 1, D);
    tbl[21] = mk(0, 0, 0, 32'h0,        0, D,        32'h100,      16'h0,    32'h102,     0, 0, D);
    tbl[22] = mk(0, 0, 0, 32'h0,        0, D,        32'h2,        16'h0,    32'h100,     1, 1, D);
    tbl[23] = mk(0, 0, 0, 32'h0,        0, D,        32'h3,        16'h0,    32'h101,     0, 1, D);
    tbl[24] = mk(0, 0, 0, 32'h0,        0, D,        32'h100,      16'h0,    32'h101,     0, 0, D);
    tbl[25] = mk(0, 0, 0, 32'h0,        0, D,        32'h101,      16'hA100, 32'h101,     0, 0, D);
    tbl[26] = mk(0, 0, 1, 32'hFFFFFFFF, 0, D,        32'hFFFFFFFF, 16'h0,    32'h102,     0, 0, D);
    tbl[27] = mk(0, 0, 0, 32'h0,        0, D,        32'h0,        16'hA1FF, 32'h0,       0, 0, D);
    tbl[28] = mk(0, 0, 0, 32'h0,        1, D,        32'h1,        16'h0000, 32'h1,       0, 0, D);
    tbl[29] = mk(0, 0, 0, 32'h0,        0, D,        32'h2,        16'h0,    32'h1,       1, 1, D);
    tbl[30] = mk(0, 0, 0, 32'h0,        0, D,        32'h3,        16'h0,    32'h2,       0, 1, D);

    rst = 1'b0;
    drive_idle();
    step();
    step();
    check("reset_out",  69'(ifc.Out),      69'h0);
    check("reset_busy", 69'(ifc.Busy),     69'h1);
    check("reset_addr", 69'(ifc.IMemAddr), 69'h0);
    rst = 1'b1;

    for (int i = 0; i < 31; i++) begin
      ifc.Stall        = tbl[i].stall;
      ifc.Flush        = tbl[i].flush;
      ifc.BranchTaken  = tbl[i].br;
      ifc.BranchTarget = tbl[i].tgt;
      ifc.IntReq       = tbl[i].irq;
      ifc.InPort       = tbl[i].ip;
      step();
      check($sformatf("row%0d_addr", i),   69'(ifc.IMemAddr),                   69'(tbl[i].addr));
      check($sformatf("row%0d_instr", i),  69'(ifc.Out[INSTR_HI:INSTR_LO]),    69'(tbl[i].instr));
      check($sformatf("row%0d_pc", i),     69'(ifc.Out[PC_HI:PC_LO]),           69'(tbl[i].pc));
      check($sformatf("row%0d_int", i),    69'(ifc.Out[INT_BIT]),               69'(tbl[i].intb));
      check($sformatf("row%0d_busy", i),   69'(ifc.Busy),                       69'(tbl[i].busy));
      check($sformatf("row%0d_inport", i), 69'(ifc.Out[INPORT_HI:INPORT_LO]),   69'(tbl[i].exp_ip));
      check($sformatf("row%0d_pad", i),    69'(ifc.Out[3:0]),                   69'h0);
    end

    // Reset landing in VEC_LO of an interrupt load: must fall back to the reset vector.
    drive_idle();
    rst = 1'b0;
    step();
    check("midrst_out",  69'(ifc.Out),      69'h0);
    check("midrst_addr", 69'(ifc.IMemAddr), 69'h0);
    check("midrst_busy", 69'(ifc.Busy),     69'h1);
    rst = 1'b1;
    step();
    check("rerun_addr_hi", 69'(ifc.IMemAddr), 69'h1);
    step();
    check("rerun_addr_run", 69'(ifc.IMemAddr), 69'h10);
    check("rerun_busy",     69'(ifc.Busy),     69'h0);
    step();
    check("rerun_instr", 69'(ifc.Out[INSTR_HI:INSTR_LO]), 69'h1234);
    check("rerun_pc",    69'(ifc.Out[PC_HI:PC_LO]),       69'h11);
    check("rerun_int",   69'(ifc.Out[INT_BIT]),           69'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
